// File: rtl/pc_fetch_unit.sv
// Program counter register and request/acknowledge instruction-fetch sequencer.
// Holds the PC, offers PC+1 back to MUX_6 and hands fetched words to decode.
module pc_fetch_unit #(
    parameter int unsigned     N        = 16,
    parameter logic [N-1:0]    RESET_PC = '0,
    parameter int unsigned     MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] MUX_6_out,
    input  logic         PC_load,
    input  logic         stall,
    input  logic         halt,
    input  logic         imem_ack,
    input  logic [N-1:0] imem_data,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    output logic [N-1:0] PC,
    output logic [N-1:0] PC_plus_one,
    output logic [N-1:0] IR,
    output logic         IR_valid,
    output logic         fetch_err
);

    localparam int unsigned    CW      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_EXEC = 2'd2,
        S_HALT = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    pc_q, pc_d;
    logic [N-1:0]    ir_q, ir_d;
    logic            ir_valid_q, ir_valid_d;
    logic            fetch_err_q, fetch_err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ir_valid_d  = 1'b0;
        fetch_err_d = fetch_err_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                state_d = halt ? S_HALT : S_REQ;
            end
            S_REQ: begin
                // Ack is checked before the timeout so a last-moment ack still delivers.
                if (halt) begin
                    state_d = S_HALT;
                end else if (imem_ack) begin
                    ir_d       = imem_data;
                    ir_valid_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_EXEC;
                end else if (cnt_q == CNT_MAX) begin
                    fetch_err_d = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXEC: begin
                if (halt) begin
                    state_d = S_HALT;
                end else if (PC_load && !stall) begin
                    pc_d    = MUX_6_out;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            fetch_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            fetch_err_q <= fetch_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign PC_plus_one = pc_q + 1'b1;
    assign IR          = ir_q;
    assign IR_valid    = ir_valid_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a cycle-level reference model checked every
// cycle, plus hand-computed literal checks along the stimulus sequence.
module tb_pc_fetch_unit;

    localparam int unsigned N        = 16;
    localparam int unsigned MAX_WAIT = 15;

    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_EXEC = 2;
    localparam int M_HALT = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] MUX_6_out;
    logic         PC_load;
    logic         stall;
    logic         halt;
    logic         imem_ack;
    logic [N-1:0] imem_data;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic [N-1:0] PC;
    logic [N-1:0] PC_plus_one;
    logic [N-1:0] IR;
    logic         IR_valid;
    logic         fetch_err;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int           m_mode   = M_IDLE;
    int           m_waited = 0;
    logic [N-1:0] m_pc     = '0;
    logic [N-1:0] m_ir     = '0;
    logic         m_valid  = 1'b0;
    logic         m_err    = 1'b0;

    pc_fetch_unit #(.N(N), .RESET_PC(16'h0000), .MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .MUX_6_out  (MUX_6_out),
        .PC_load    (PC_load),
        .stall      (stall),
        .halt       (halt),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .PC         (PC),
        .PC_plus_one(PC_plus_one),
        .IR         (IR),
        .IR_valid   (IR_valid),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a fetch waits at most MAX_WAIT+1 request cycles before giving up.
    task automatic model_step();
        if (reset) begin
            m_mode = M_IDLE; m_waited = 0; m_pc = '0; m_ir = '0; m_valid = 1'b0; m_err = 1'b0;
            return;
        end
        m_valid = 1'b0;
        case (m_mode)
            M_IDLE: begin
                m_waited = 0;
                m_mode   = halt ? M_HALT : M_REQ;
            end
            M_REQ: begin
                if (halt) m_mode = M_HALT;
                else if (imem_ack) begin
                    m_ir = imem_data; m_valid = 1'b1; m_mode = M_EXEC;
                end else begin
                    m_waited = m_waited + 1;
                    if (m_waited > int'(MAX_WAIT)) begin
                        m_err = 1'b1; m_mode = M_HALT;
                    end
                end
            end
            M_EXEC: begin
                if (halt) m_mode = M_HALT;
                else if (PC_load && !stall) begin
                    m_pc = MUX_6_out; m_waited = 0; m_mode = M_REQ;
                end
            end
            default: m_mode = M_HALT;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            logic [N-1:0] exp_plus;
            exp_plus = m_pc + 16'd1;
            check("cyc_imem_req",    32'(imem_req),    32'(m_mode == M_REQ));
            check("cyc_imem_addr",   32'(imem_addr),   32'(m_pc));
            check("cyc_PC",          32'(PC),          32'(m_pc));
            check("cyc_PC_plus_one", 32'(PC_plus_one), 32'(exp_plus));
            check("cyc_IR",          32'(IR),          32'(m_ir));
            check("cyc_IR_valid",    32'(IR_valid),    32'(m_valid));
            check("cyc_fetch_err",   32'(fetch_err),   32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; MUX_6_out = '0; PC_load = 1'b0; stall = 1'b0;
        halt = 1'b0; imem_ack = 1'b0; imem_data = '0;

        // Reset for two cycles
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_PC", 32'(PC), 32'h0);
        check("rst_IR", 32'(IR), 32'h0);
        check("rst_IR_valid", 32'(IR_valid), 32'h0);
        check("rst_err", 32'(fetch_err), 32'h0);

        // Sequential fetch, ack in first REQ cycle
        reset = 1'b0;
        tick();
        check("seq_req", 32'(imem_req), 32'h1);
        check("seq_addr", 32'(imem_addr), 32'h0);
        imem_ack = 1'b1; imem_data = 16'h1234;
        tick();
        check("seq_IR", 32'(IR), 32'h1234);
        check("seq_IR_valid", 32'(IR_valid), 32'h1);
        check("seq_plus1", 32'(PC_plus_one), 32'h1);
        imem_ack = 1'b0; MUX_6_out = 16'h0001; PC_load = 1'b1;
        tick();
        check("seq_PC", 32'(PC), 32'h1);
        check("seq_addr1", 32'(imem_addr), 32'h1);
        check("seq_req1", 32'(imem_req), 32'h1);
        check("seq_valid_pulse", 32'(IR_valid), 32'h0);
        PC_load = 1'b0; imem_ack = 1'b1; imem_data = 16'hABCD;
        tick();
        imem_ack = 1'b0;

        // Branch load
        MUX_6_out = 16'h0020; PC_load = 1'b1;
        tick();
        check("br_PC", 32'(PC), 32'h20);
        check("br_req", 32'(imem_req), 32'h1);
        check("br_addr", 32'(imem_addr), 32'h20);
        check("br_plus1", 32'(PC_plus_one), 32'h21);
        PC_load = 1'b0; imem_ack = 1'b1; imem_data = 16'h5555;
        tick();
        imem_ack = 1'b0;

        // Stall holds a pending load for three cycles
        MUX_6_out = 16'h0040; PC_load = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_PC", 32'(PC), 32'h20);
            check("stall_req", 32'(imem_req), 32'h0);
        end
        stall = 1'b0;
        tick();
        check("unstall_PC", 32'(PC), 32'h40);
        check("unstall_req", 32'(imem_req), 32'h1);
        PC_load = 1'b0;

        // Ack arrives on the final allowed wait cycle
        for (int i = 0; i < 15; i++) tick();
        check("late_ok_req", 32'(imem_req), 32'h1);
        imem_ack = 1'b1; imem_data = 16'h7777;
        tick();
        check("late_ok_IR", 32'(IR), 32'h7777);
        check("late_ok_err", 32'(fetch_err), 32'h0);
        check("late_ok_valid", 32'(IR_valid), 32'h1);
        imem_ack = 1'b0;

        // Timeout: no ack ever
        MUX_6_out = 16'h0050; PC_load = 1'b1;
        tick();
        PC_load = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("to_req_held", 32'(imem_req), 32'h1);
        end
        tick();
        check("to_err", 32'(fetch_err), 32'h1);
        check("to_req_low", 32'(imem_req), 32'h0);
        imem_ack = 1'b1; imem_data = 16'h9999; PC_load = 1'b1; MUX_6_out = 16'h0060;
        tick();
        tick();
        check("halt_IR", 32'(IR), 32'h7777);
        check("halt_PC", 32'(PC), 32'h50);
        check("halt_req", 32'(imem_req), 32'h0);
        check("halt_err", 32'(fetch_err), 32'h1);
        imem_ack = 1'b0; PC_load = 1'b0;

        // Wrap and halt priority
        reset = 1'b1;
        tick();
        check("rst2_err", 32'(fetch_err), 32'h0);
        reset = 1'b0;
        tick();
        imem_ack = 1'b1; imem_data = 16'h1111;
        tick();
        imem_ack = 1'b0; MUX_6_out = 16'hFFFF; PC_load = 1'b1;
        tick();
        check("wrap_PC", 32'(PC), 32'hFFFF);
        check("wrap_plus1", 32'(PC_plus_one), 32'h0000);
        PC_load = 1'b0; imem_ack = 1'b1; imem_data = 16'h2222;
        tick();
        imem_ack = 1'b0; halt = 1'b1; PC_load = 1'b1; MUX_6_out = 16'h0100;
        tick();
        check("hp_PC", 32'(PC), 32'hFFFF);
        check("hp_req", 32'(imem_req), 32'h0);
        halt = 1'b0;
        tick();
        check("hp_PC_hold", 32'(PC), 32'hFFFF);
        check("hp_IR_hold", 32'(IR), 32'h2222);
        PC_load = 1'b0;

        // Reset asserted in the middle of a request
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        imem_ack = 1'b1; imem_data = 16'h3333;
        tick();
        imem_ack = 1'b0; MUX_6_out = 16'h0033; PC_load = 1'b1;
        tick();
        PC_load = 1'b0;
        check("mid_req_before", 32'(imem_req), 32'h1);
        check("mid_PC_before", 32'(PC), 32'h33);
        reset = 1'b1;
        tick();
        check("mid_req_after", 32'(imem_req), 32'h0);
        check("mid_PC_after", 32'(PC), 32'h0);

        // Halt straight out of IDLE
        halt = 1'b1; reset = 1'b0;
        tick();
        halt = 1'b0; imem_ack = 1'b1;
        tick();
        check("idle_halt_req", 32'(imem_req), 32'h0);
        check("idle_halt_IR", 32'(IR), 32'h0);
        imem_ack = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program counter register and instruction-fetch sequencer.
- Sits directly downstream of MUX_6: registers MUX_6_out as the next PC.
- Produces PC_plus_one, which feeds back into MUX_6.
- Runs a request/acknowledge fetch to instruction memory and presents the fetched word to decode.

Parameters:
N, 16, datapath/address width in bits
RESET_PC, 0, PC value loaded on reset
MAX_WAIT, 15, cycles REQ may wait for imem_ack before fetch error (1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
MUX_6_out  input  N  next-PC value selected by MUX_6
PC_load  input  1  control pulse: commit MUX_6_out as new PC
stall  input  1  blocks PC_load while high
halt  input  1  stop fetching; enter HALT
imem_ack  input  1  instruction memory has valid data on imem_data
imem_data  input  N  instruction word from memory
imem_req  output  1  fetch request, high only in REQ
imem_addr  output  N  fetch address, always equals PC
PC  output  N  current program counter
PC_plus_one  output  N  PC+1 modulo 2^N, combinational, to MUX_6
IR  output  N  last fetched instruction
IR_valid  output  1  one-cycle pulse when IR is updated
fetch_err  output  1  sticky timeout flag

Behaviour:
- Reset (sampled at clk edge): PC=RESET_PC, IR=0, IR_valid=0, fetch_err=0, wait counter=0, state=IDLE.
  - imem_req is low in IDLE. A reset asserted mid-REQ drops imem_req from the next cycle.
- States: IDLE, REQ, EXEC, HALT. imem_req = (state==REQ). imem_addr = PC.
- IDLE: if halt -> HALT, else -> REQ (one cycle after reset release).
- REQ: each edge, priority order:
  - 1. halt -> HALT; fetch abandoned, IR unchanged.
  - 2. imem_ack -> IR<=imem_data, IR_valid<=1, counter<=0, -> EXEC. Ack wins over timeout in the same cycle.
  - 3. counter==MAX_WAIT -> fetch_err<=1, -> HALT.
  - 4. Otherwise counter<=counter+1.
  - Minimum fetch latency: ack in the first REQ cycle gives IR_valid on the next cycle.
- EXEC: IR_valid is high only in the first EXEC cycle. Priority order:
  - 1. halt -> HALT.
  - 2. PC_load && !stall -> PC<=MUX_6_out, -> REQ. The new address is visible on imem_addr in the same cycle imem_req rises.
  - 3. Otherwise hold. A PC_load held under stall is honoured in the first cycle stall drops, provided PC_load is still high.
- HALT: absorbing; PC, IR and fetch_err hold; imem_req=0. Only reset exits.
- PC_load outside EXEC is ignored. imem_ack outside REQ is ignored.
- Arithmetic: PC_plus_one = PC + 1 truncated to N bits, so 0xFFFF -> 0x0000 at N=16. No carry out.
- fetch_err is cleared only by reset.
- Counter width: ceil(log2(MAX_WAIT+1)) bits. It never exceeds MAX_WAIT.

Test Plan:
- Reset, then sequential fetch: reset high for 2 cycles, RESET_PC=0; memory acks in the first REQ cycle with 0x1234. Required: imem_req high with imem_addr=0; next cycle IR=0x1234 and IR_valid=1 for exactly 1 cycle; PC_plus_one=1. Then drive PC_load with MUX_6_out=PC_plus_one: PC=1 and the next request is at address 1.
- Branch load: in EXEC, MUX_6_out=0x0020 and PC_load=1. Required: PC=0x0020 next cycle, imem_req=1, imem_addr=0x0020; PC_plus_one=0x0021.
- Stall: in EXEC, PC_load=1 and stall=1 for 3 cycles, then stall=0. Required: PC unchanged and imem_req=0 during the stall; PC updates on the first cycle with stall=0.
- Timeout: never ack, MAX_WAIT=15. Required: imem_req high for 16 cycles, then fetch_err=1, state HALT, imem_req=0. A late imem_ack and PC_load have no effect.
- Ack on the timeout cycle: ack arrives exactly when counter==MAX_WAIT. Required: IR loaded, fetch_err=0, state EXEC.
- Wrap and halt priority: force PC=0xFFFF via PC_load. Required: PC_plus_one=0x0000. Then assert halt and PC_load together in EXEC: required HALT with PC still 0xFFFF. Reset mid-REQ: required imem_req=0 and PC=RESET_PC the following cycle.
